// File: rtl/allo_feeder.sv
// Host-to-controller allophone FIFO with a one-shot ldq/data_stb handshake.
// Optional: define ALLO_FEEDER_AUTOSILENCE_EN to append one pause (code 0) after the queue drains.
module allo_feeder #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_an,
    input  logic [5:0]               wr_data,
    input  logic                     wr_stb,
    input  logic                     flush,
    input  logic                     ldq,
    output logic [5:0]               data_out,
    output logic                     data_stb,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAITLOW} state_t;

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q;
    logic          stb_q;
    logic [5:0]    dout_q;
    logic [5:0]    mem_q [DEPTH];

    logic fifo_full, fifo_empty;
    logic pop, push, ovf_set, sil;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);

    // Flush wins over both ends of the queue; a full queue still accepts a write when a pop frees a slot.
    assign pop     = (state_q == S_IDLE) && ldq && !fifo_empty && !flush;
    assign push    = wr_stb && !flush && (!fifo_full || pop);
    assign ovf_set = wr_stb && !flush && fifo_full && !pop;

`ifdef ALLO_FEEDER_AUTOSILENCE_EN
    logic armed_q;
    assign sil = (state_q == S_IDLE) && ldq && fifo_empty && armed_q && !flush;
`else
    assign sil = 1'b0;
`endif

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (pop && !push)
            count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            stb_q    <= 1'b0;
            dout_q   <= '0;
`ifdef ALLO_FEEDER_AUTOSILENCE_EN
            armed_q  <= 1'b0;
`endif
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
`ifdef ALLO_FEEDER_AUTOSILENCE_EN
                armed_q  <= 1'b0;
`endif
            end else begin
                count_q <= count_d;
                if (push)
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                if (ovf_set)
                    ovf_q <= 1'b1;
`ifdef ALLO_FEEDER_AUTOSILENCE_EN
                if (pop)
                    armed_q <= (count_q == CNT_ONE) && !push;
                else if (sil)
                    armed_q <= 1'b0;
`endif
            end

            // The controller sees one strobe per ldq high phase; WAITLOW holds off until ldq drops.
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        dout_q  <= mem_q[rd_ptr_q];
                        stb_q   <= 1'b1;
                        state_q <= S_STROBE;
                    end else if (sil) begin
                        dout_q  <= '0;
                        stb_q   <= 1'b1;
                        state_q <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    stb_q   <= 1'b0;
                    state_q <= S_WAITLOW;
                end
                S_WAITLOW: begin
                    if (!ldq)
                        state_q <= S_IDLE;
                end
                default: begin
                    stb_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out = dout_q;
    assign data_stb = stb_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign level    = count_q;
    assign overflow = ovf_q;
    assign busy     = !fifo_empty || (state_q != S_IDLE);

endmodule
